// File: rtl/bt_cmd_decoder_pkg.sv
// Shared definitions for the Bluetooth command decoder: opcodes, parser
// state encoding, ASCII constants and small cursor helpers.
package bt_cmd_pkg;

  localparam int BOARD_N = 9;
  localparam int CW      = 4;  // width of row/column/digit fields

  localparam logic [2:0] OP_SET  = 3'd0;
  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_CUR  = 3'd2;
  localparam logic [2:0] OP_NEW  = 3'd3;
  localparam logic [2:0] OP_UNDO = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_P_ROW = 2'd1,
    ST_P_COL = 2'd2,
    ST_P_DIG = 2'd3
  } state_t;

  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_S  = 8'h53;
  localparam logic [7:0] CH_D  = 8'h44;
  localparam logic [7:0] CH_X  = 8'h58;
  localparam logic [7:0] CH_N  = 8'h4E;
  localparam logic [7:0] CH_U  = 8'h55;
  localparam logic [7:0] CH_P  = 8'h50;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_9  = 8'h39;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;

  // Lowercase letters map onto uppercase by clearing bit 5.
  function automatic logic [7:0] fold_case(input logic [7:0] b);
    return (b >= 8'h61 && b <= 8'h7A) ? (b & 8'hDF) : b;
  endfunction

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
    return (v == CW'(BOARD_N - 1)) ? '0 : v + CW'(1);
  endfunction

  function automatic logic [CW-1:0] wrap_dec(input logic [CW-1:0] v);
    return (v == '0) ? CW'(BOARD_N - 1) : v - CW'(1);
  endfunction

endpackage

// File: rtl/bt_cmd_decoder_if.sv
// Byte-in / command-out bus of the decoder.
// Handshake: in_en is a one-cycle strobe qualifying in_data (no back-pressure).
// The command side is valid/ready: a command transfers on any edge where
// cmd_valid and cmd_ready are both high; cmd_* fields are stable while
// cmd_valid is high and cmd_ready is low.
interface bt_cmd_decoder_if;
  import bt_cmd_pkg::*;

  logic [7:0]    in_data;
  logic          in_en;
  logic          cmd_ready;
  logic          cmd_valid;
  logic [2:0]    cmd_op;
  logic [CW-1:0] cmd_row;
  logic [CW-1:0] cmd_col;
  logic [CW-1:0] cmd_val;

  modport master (
    output in_data, in_en, cmd_ready,
    input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_val
  );

  modport slave (
    input  in_data, in_en, cmd_ready,
    output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_val
  );
endinterface

// File: rtl/bt_cmd_timer.sv
// Clearable inter-byte timeout counter. Counts while i_run is high and no
// byte arrives; o_expire is high for one cycle when the count reaches
// CYCLES-1. A byte in the same cycle wins over expiry.
module bt_cmd_timer #(
  parameter int CYCLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);
  localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_expire = i_run && !i_clear && (r_cnt == CNT_W'(CYCLES - 1));

  // Count idle cycles; restart on a byte, outside P states, or on expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             r_cnt <= '0;
    else if (i_clear || !i_run || o_expire) r_cnt <= '0;
    else                                  r_cnt <= r_cnt + CNT_W'(1);
  end
endmodule

// File: rtl/bt_cmd_decoder.sv
// ASCII command decoder behind the Bluetooth UART receiver. Decodes single
// key moves/digits and the 4-byte "P r c d" place command, tracks the board
// cursor and holds one decoded command in a valid/ready output register.
// Optional feature: define BT_CMD_TIMEOUT_EN to abort a stalled P command
// after TIMEOUT_CYCLES idle cycles.
module bt_cmd_decoder
  import bt_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic          clk,
  input  logic          rst,
  bt_cmd_decoder_if.slave bus,
  output logic [CW-1:0] cur_row,
  output logic [CW-1:0] cur_col,
  output logic          err,
  output logic          drop,
  output state_t        dbg_state
);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cur_row, r_cur_col, r_p_row, r_p_col;
  logic          r_cmd_valid, r_err, r_drop;
  logic [2:0]    r_cmd_op;
  logic [CW-1:0] r_cmd_row, r_cmd_col, r_cmd_val;

  logic [7:0]    w_byte;
  logic          w_is_d19, w_is_d09;
  logic          w_emit, w_bad, w_load, w_expire;
  logic [2:0]    w_op;
  logic [CW-1:0] w_row, w_col, w_val;

  assign w_byte   = fold_case(bus.in_data);
  assign w_is_d19 = (w_byte >= CH_1) && (w_byte <= CH_9);
  assign w_is_d09 = (w_byte >= CH_0) && (w_byte <= CH_9);

`ifdef BT_CMD_TIMEOUT_EN
  bt_cmd_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (bus.in_en),
    .i_run    (r_state != ST_IDLE),
    .o_expire (w_expire)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_expire         = 1'b0;
`endif

  // Parser state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next parser state: P opens the sequence, bad bytes or timeout close it.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.in_en) begin
      case (r_state)
        ST_IDLE:  if (w_byte == CH_P) w_state_nxt = ST_P_ROW;
        ST_P_ROW: w_state_nxt = w_is_d19 ? ST_P_COL : ST_IDLE;
        ST_P_COL: w_state_nxt = w_is_d19 ? ST_P_DIG : ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end else if (w_expire) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Decode the current byte into a candidate command or a protocol error.
  always_comb begin
    w_emit = 1'b0;
    w_bad  = 1'b0;
    w_op   = OP_CUR;
    w_row  = r_cur_row;
    w_col  = r_cur_col;
    w_val  = '0;
    if (bus.in_en) begin
      case (r_state)
        ST_IDLE: begin
          w_emit = 1'b1;
          if      (w_byte == CH_W) w_row = wrap_dec(r_cur_row);
          else if (w_byte == CH_S) w_row = wrap_inc(r_cur_row);
          else if (w_byte == CH_A) w_col = wrap_dec(r_cur_col);
          else if (w_byte == CH_D) w_col = wrap_inc(r_cur_col);
          else if (w_is_d19) begin
            w_op  = OP_SET;
            w_val = w_byte[3:0];
          end
          else if (w_byte == CH_0 || w_byte == CH_X) w_op = OP_CLR;
          else if (w_byte == CH_N) w_op = OP_NEW;
          else if (w_byte == CH_U) w_op = OP_UNDO;
          else begin
            w_emit = 1'b0;
            w_bad  = !(w_byte == CH_P || w_byte == CH_CR ||
                       w_byte == CH_LF || w_byte == CH_SP);
          end
        end
        ST_P_ROW, ST_P_COL: w_bad = !w_is_d19;
        default: begin
          if (w_is_d09) begin
            w_emit = 1'b1;
            w_row  = r_p_row;
            w_col  = r_p_col;
            w_op   = (w_byte == CH_0) ? OP_CLR : OP_SET;
            w_val  = w_byte[3:0];
          end else begin
            w_bad  = 1'b1;
          end
        end
      endcase
    end
  end

  // A command is taken only if the output slot is free or draining now.
  assign w_load = w_emit && (!r_cmd_valid || bus.cmd_ready);

  // Capture the 1-based row/column of a P command as 0-based coordinates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_p_row <= '0;
      r_p_col <= '0;
    end else if (bus.in_en && w_is_d19) begin
      if (r_state == ST_P_ROW) r_p_row <= w_byte[3:0] - CW'(1);
      if (r_state == ST_P_COL) r_p_col <= w_byte[3:0] - CW'(1);
    end
  end

  // Cursor follows only commands that were actually accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_row <= '0;
      r_cur_col <= '0;
    end else if (w_load) begin
      r_cur_row <= w_row;
      r_cur_col <= w_col;
    end
  end

  // One-entry command output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= '0;
      r_cmd_row   <= '0;
      r_cmd_col   <= '0;
      r_cmd_val   <= '0;
    end else if (w_load) begin
      r_cmd_valid <= 1'b1;
      r_cmd_op    <= w_op;
      r_cmd_row   <= w_row;
      r_cmd_col   <= w_col;
      r_cmd_val   <= w_val;
    end else if (bus.cmd_ready) begin
      r_cmd_valid <= 1'b0;
    end
  end

  // Single-cycle error and drop pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_err  <= w_bad || w_expire;
      r_drop <= w_emit && !w_load;
    end
  end

  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd_op    = r_cmd_op;
  assign bus.cmd_row   = r_cmd_row;
  assign bus.cmd_col   = r_cmd_col;
  assign bus.cmd_val   = r_cmd_val;
  assign cur_row       = r_cur_row;
  assign cur_col       = r_cur_col;
  assign err           = r_err;
  assign drop          = r_drop;
  assign dbg_state     = r_state;

endmodule

// File: doc/bt_cmd_decoder.md
# bt_cmd_decoder

Byte-level command decoder sitting directly downstream of the Bluetooth UART receiver. It consumes the receiver's 8-bit byte plus one-cycle `in_en` strobe, parses a small ASCII command protocol (single-key moves/digits and a 4-byte absolute "place" command), and tracks the board cursor. It presents decoded Sudoku commands to the game core through a one-entry valid/ready output register.

## Interface
- `TIMEOUT_CYCLES`, default 50_000_000: maximum idle gap between bytes of a `P` command (0.5 s at 100 MHz).
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: reset, asynchronous assert, active-low.
- `in_data` input 8: received byte, valid only when `in_en`=1.
- `in_en` input 1: one-cycle byte strobe from the UART receiver.
- `cmd_ready` input 1: game core accepts the command this cycle.
- `cmd_valid` output 1: command present; held until accepted.
- `cmd_op` output 3: opcode (SET, CLR, CUR, NEW, UNDO).
- `cmd_row` output 4: target row, 0..8.
- `cmd_col` output 4: target column, 0..8.
- `cmd_val` output 4: digit 1..9 for SET, 0 otherwise.
- `cur_row` output 4: current cursor row.
- `cur_col` output 4: current cursor column.
- `err` output 1: one-cycle pulse on a protocol error or timeout.
- `drop` output 1: one-cycle pulse when a decoded command is discarded because the output register is full.

## Operation
- Letters are case-insensitive; clear bit 5 of bytes 0x61..0x7A before matching.
- IDLE byte map:
  - `W`/`S`: row −1/+1, mod 9 (0→8, 8→0); emit CUR.
  - `A`/`D`: column −1/+1, mod 9; emit CUR.
  - `1`..`9`: emit SET at cursor with that digit.
  - `0` or `X`: emit CLR at cursor.
  - `N`: emit NEW.
  - `U`: emit UNDO.
  - `P`: go to P_ROW and emit nothing.
  - CR, LF, space: ignored.
  - Any other byte: `err`.
- P sequence, states P_ROW → P_COL → P_DIG:
  - Row and column bytes must be `1`..`9` (1-based).
  - Digit byte must be `0`..`9`.
  - On the digit byte, the cursor moves to (r−1, c−1). The block emits SET with the digit, or CLR if the digit is `0`, then returns to IDLE.
  - An invalid byte in any P state raises `err` and returns to IDLE. That byte is consumed and not re-decoded.
- NEW, UNDO and CUR carry the cursor position (after the move) in `cmd_row`/`cmd_col`.
- Output register: load on emit when `cmd_valid`=0 or `cmd_ready`=1. Otherwise pulse `drop`, discard the command and leave the cursor unchanged. Parser state still advances.
- `cmd_valid` and `cmd_ready` high with no new command: `cmd_valid` goes low next edge.
- Reset mid-operation: state returns to IDLE and any P sequence in progress is lost.

## Timing
- `in_en` sampled high at edge k: `cmd_valid`, `cur_row`/`cur_col`, `err` and `drop` update at edge k (visible the cycle after). Latency is 1 cycle.
- Throughput: one command per cycle. Back-to-back accepted commands keep `cmd_valid` high.
- Timeout counter: cleared on every `in_en`, counts only in P states. On reaching `TIMEOUT_CYCLES`−1 without a byte: `err` pulse and return to IDLE. If `in_en` arrives in the same cycle, the byte takes priority and no timeout occurs.
- Reset values: every output is 0; state IDLE; counter 0.

## Configuration
- `BT_CMD_TIMEOUT_EN` defined: the inter-byte timeout is active as above.
- Undefined: the counter is removed. P states wait indefinitely and are left only through a byte or reset. `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `bt_cmd_pkg`:
  - opcode constants: SET=0, CLR=1, CUR=2, NEW=3, UNDO=4;
  - parser state encoding (IDLE, P_ROW, P_COL, P_DIG);
  - ASCII constants used by the map;
  - `BOARD_N`=9.
- Sub-module `bt_cmd_timer`: the clearable timeout counter with a one-cycle `expire` output. It is instantiated only under `BT_CMD_TIMEOUT_EN`.

## Test plan
- Reset, then bytes `D`,`D`,`S` with `cmd_ready`=1: three CUR commands at (0,1), (0,2), (1,2); `cur_row`=1, `cur_col`=2.
- From (0,0), send `w` then `a`: CUR (8,0) then CUR (8,8), exercising wrap and lowercase.
- Send `P`,`3`,`7`,`5`: single SET row=2, col=6, val=5; cursor (2,6). Then `P`,`1`,`1`,`0`: CLR at (0,0).
- Send `P`,`0`: `err` pulse and state IDLE. Then `5`: SET at the current cursor, val=5.
- Hold `cmd_ready`=0 and send `4` then `6`: first SET (val 4) held; `drop` pulses on `6`; releasing `cmd_ready` yields SET val 4 only.
- With `BT_CMD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=100, send `P`,`2` then idle for 100 cycles: `err` pulse and IDLE. Send `9`: SET val 9 at the unchanged cursor.
